// File: rtl/eth_rx_pkg.sv
// Shared types and constants for the GMII receive buffer controller.
// Optional build macro RX_FCS_STRIP_EN is consumed by eth_rx_buf_ctrl.
package eth_rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    DATA     = 3'd2,
    DROP     = 3'd3,
    COMMIT   = 3'd4
  } state_t;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam int unsigned ETH_FCS_LEN  = 4;

endpackage

// File: rtl/eth_rx_buf_ctrl_slot_mgr.sv
// Two-slot ownership tracker: full flags, latched lengths, write/read pointers
// and the commit/ack handshake toward the frame consumer.
module eth_rx_buf_ctrl_slot_mgr #(
  parameter int unsigned BUF_AW = 10
) (
  input  logic              phy1_125M_clk,
  input  logic              reset_n,
  input  logic              commit,
  input  logic [BUF_AW:0]   commit_len,
  input  logic              ack,
  output logic              wslot,
  output logic              slot_free_c,
  output logic              frm_valid,
  output logic              frm_slot,
  output logic [BUF_AW:0]   frm_len
);
  import eth_rx_pkg::*;

  localparam int unsigned LW = BUF_AW + 1;

  logic [1:0]    full_q, full_d;
  logic [LW-1:0] len_q [2];
  logic [LW-1:0] len_d [2];
  logic          rslot_q, rslot_d, wslot_d;

  assign slot_free_c = !full_q[wslot];

  // Commit and ack never collide on a slot: a commit targets an empty slot, an ack a full one.
  always_comb begin
    full_d  = full_q;
    len_d   = len_q;
    wslot_d = wslot;
    rslot_d = rslot_q;
    if (commit) begin
      full_d[wslot] = 1'b1;
      len_d[wslot]  = commit_len;
      wslot_d       = ~wslot;
    end
    if (ack && full_q[rslot_q]) begin
      full_d[rslot_q] = 1'b0;
      rslot_d         = ~rslot_q;
    end
  end

  // Reader-facing outputs are registered from the next-state view so they track full/rslot exactly.
  always_ff @(posedge phy1_125M_clk) begin
    if (!reset_n) begin
      full_q    <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      wslot     <= 1'b0;
      rslot_q   <= 1'b0;
      frm_valid <= 1'b0;
      frm_slot  <= 1'b0;
      frm_len   <= '0;
    end else begin
      full_q    <= full_d;
      len_q     <= len_d;
      wslot     <= wslot_d;
      rslot_q   <= rslot_d;
      frm_valid <= full_d[rslot_d];
      frm_slot  <= rslot_d;
      frm_len   <= len_d[rslot_d];
    end
  end

endmodule

// File: rtl/eth_rx_buf_ctrl.sv
// GMII receive frame controller: strips preamble/SFD, writes payload into a two-slot
// buffer, commits or discards frames. Optional macro RX_FCS_STRIP_EN trims FCS from frm_len.
module eth_rx_buf_ctrl #(
  parameter int unsigned BUF_AW  = 10,
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              phy1_125M_clk,
  input  logic              reset_n,
  input  logic              rx_dv,
  input  logic [7:0]        rx_data,
  output logic              buf_we,
  output logic [BUF_AW:0]   buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic              frm_valid,
  output logic              frm_slot,
  output logic [BUF_AW:0]   frm_len,
  input  logic              frm_ack,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  runt_cnt
);
  import eth_rx_pkg::*;

  localparam int unsigned   LW         = BUF_AW + 1;
  localparam logic [LW-1:0] SLOT_BYTES = LW'(1) << BUF_AW;

  state_t        state, state_d;
  logic          rx_dv_q;
  logic [LW-1:0] length, length_d;
  logic          we_d;
  logic [LW-1:0] waddr_d;
  logic [7:0]    wdata_d;
  logic          drop_inc_c, runt_inc_c, commit_c;
  logic          wslot, slot_free_c;
  logic [LW-1:0] commit_len_c;

`ifdef RX_FCS_STRIP_EN
  assign commit_len_c = length - LW'(ETH_FCS_LEN);
`else
  assign commit_len_c = length;
`endif

  eth_rx_buf_ctrl_slot_mgr #(.BUF_AW(BUF_AW)) u_slot_mgr (
    .phy1_125M_clk (phy1_125M_clk),
    .reset_n       (reset_n),
    .commit        (commit_c),
    .commit_len    (commit_len_c),
    .ack           (frm_ack),
    .wslot         (wslot),
    .slot_free_c   (slot_free_c),
    .frm_valid     (frm_valid),
    .frm_slot      (frm_slot),
    .frm_len       (frm_len)
  );

  always_ff @(posedge phy1_125M_clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      rx_dv_q   <= 1'b0;
      length    <= '0;
      buf_we    <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
      drop_cnt  <= '0;
      runt_cnt  <= '0;
    end else begin
      state     <= state_d;
      rx_dv_q   <= rx_dv;
      length    <= length_d;
      buf_we    <= we_d;
      buf_waddr <= waddr_d;
      buf_wdata <= wdata_d;
      if (drop_inc_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
      if (runt_inc_c && (runt_cnt != '1)) runt_cnt <= runt_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state;
    length_d   = length;
    we_d       = 1'b0;
    waddr_d    = buf_waddr;
    wdata_d    = buf_wdata;
    drop_inc_c = 1'b0;
    runt_inc_c = 1'b0;
    commit_c   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_dv && !rx_dv_q) begin
          if (rx_data == ETH_PREAMBLE) begin
            state_d = PREAMBLE;
          end else begin
            state_d    = DROP;
            drop_inc_c = 1'b1;
          end
        end
      end
      PREAMBLE: begin
        if (!rx_dv) begin
          state_d = IDLE;
        end else if (rx_data == ETH_PREAMBLE) begin
          state_d = PREAMBLE;
        end else if ((rx_data == ETH_SFD) && slot_free_c) begin
          state_d  = DATA;
          length_d = '0;
        end else begin
          state_d    = DROP;
          drop_inc_c = 1'b1;
        end
      end
      DATA: begin
        if (!rx_dv) begin
          if (length >= LW'(MIN_LEN)) begin
            state_d = COMMIT;
          end else begin
            state_d    = IDLE;
            runt_inc_c = 1'b1;
          end
        end else if (length == SLOT_BYTES) begin
          state_d    = DROP;
          drop_inc_c = 1'b1;
        end else begin
          we_d     = 1'b1;
          waddr_d  = {wslot, length[BUF_AW-1:0]};
          wdata_d  = rx_data;
          length_d = length + LW'(1);
        end
      end
      COMMIT: begin
        commit_c = 1'b1;
        state_d  = IDLE;
      end
      DROP: begin
        if (!rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_rx_buf_ctrl.sv
// Directed self-checking bench for eth_rx_buf_ctrl (default parameters).
module tb_eth_rx_buf_ctrl;

  localparam int unsigned BUF_AW  = 10;
  localparam int unsigned MIN_LEN = 60;
  localparam int unsigned CNT_W   = 16;
`ifdef RX_FCS_STRIP_EN
  localparam int unsigned LEN64 = 60;
`else
  localparam int unsigned LEN64 = 64;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              rx_dv = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              frm_ack = 1'b0;
  logic              buf_we;
  logic [BUF_AW:0]   buf_waddr;
  logic [7:0]        buf_wdata;
  logic              frm_valid;
  logic              frm_slot;
  logic [BUF_AW:0]   frm_len;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  runt_cnt;

  int checks = 0;
  int errors = 0;

  logic [BUF_AW:0] wa [$];
  logic [7:0]      wd [$];

  eth_rx_buf_ctrl #(.BUF_AW(BUF_AW), .MIN_LEN(MIN_LEN), .CNT_W(CNT_W)) dut (
    .phy1_125M_clk (clk),
    .reset_n       (reset_n),
    .rx_dv         (rx_dv),
    .rx_data       (rx_data),
    .buf_we        (buf_we),
    .buf_waddr     (buf_waddr),
    .buf_wdata     (buf_wdata),
    .frm_valid     (frm_valid),
    .frm_slot      (frm_slot),
    .frm_len       (frm_len),
    .frm_ack       (frm_ack),
    .drop_cnt      (drop_cnt),
    .runt_cnt      (runt_cnt)
  );

  always #4 clk = ~clk;

  always @(negedge clk) begin
    if (buf_we) begin
      wa.push_back(buf_waddr);
      wd.push_back(buf_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic byte_in(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_data = b;
    tick();
  endtask

  // Preamble, SFD, n bytes of pattern i[7:0], then rx_dv low sampled on one edge.
  task automatic frame(input int npre, input int n);
    for (int i = 0; i < npre; i++) byte_in(8'h55);
    byte_in(8'hD5);
    for (int i = 0; i < n; i++) byte_in(8'(i));
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rx_dv   = 1'b0;
    frm_ack = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic ack_once();
    frm_ack = 1'b1;
    tick();
    frm_ack = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n, input int slot);
    int bad;
    bad = 0;
    foreach (wa[i]) begin
      if (wa[i] !== 11'(slot * 1024 + i)) bad++;
      if (wd[i] !== 8'(i)) bad++;
    end
    check({tag, "_count"}, 32'(wa.size()), 32'(n));
    check({tag, "_content"}, 32'(bad), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},    32'(buf_we),    32'd0);
    check({tag, "_waddr"}, 32'(buf_waddr), 32'd0);
    check({tag, "_wdata"}, 32'(buf_wdata), 32'd0);
    check({tag, "_valid"}, 32'(frm_valid), 32'd0);
    check({tag, "_slot"},  32'(frm_slot),  32'd0);
    check({tag, "_len"},   32'(frm_len),   32'd0);
    check({tag, "_drop"},  32'(drop_cnt),  32'd0);
    check({tag, "_runt"},  32'(runt_cnt),  32'd0);
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    tick();
    tick();
    check_all_zero("rst");
    reset_n = 1'b1;
    tick();

    // Single legal frame into slot 0
    wa.delete(); wd.delete();
    frame(7, 64);
    check("t1_valid_early", 32'(frm_valid), 32'd0);
    tick();
    check("t1_valid", 32'(frm_valid), 32'd1);
    check("t1_slot",  32'(frm_slot),  32'd0);
    check("t1_len",   32'(frm_len),   32'(LEN64));
    check_writes("t1_wr", 64, 0);

    // Three frames without ack: third dropped for lack of a free slot
    do_reset();
    frame(7, 64); tick(); tick();
    frame(7, 64); tick(); tick();
    check("t2_valid", 32'(frm_valid), 32'd1);
    check("t2_slot0", 32'(frm_slot),  32'd0);
    wa.delete(); wd.delete();
    frame(7, 64); tick(); tick();
    check("t2_wr_none", 32'(wa.size()), 32'd0);
    check("t2_drop",    32'(drop_cnt),  32'd1);
    ack_once();
    check("t2_ack_valid", 32'(frm_valid), 32'd1);
    check("t2_ack_slot",  32'(frm_slot),  32'd1);
    check("t2_ack_len",   32'(frm_len),   32'(LEN64));
    ack_once();
    check("t2_empty_valid", 32'(frm_valid), 32'd0);
    check("t2_empty_slot",  32'(frm_slot),  32'd0);
    ack_once();
    check("t2_ign_valid", 32'(frm_valid), 32'd0);
    check("t2_ign_slot",  32'(frm_slot),  32'd0);

    // Runt frame
    wa.delete(); wd.delete();
    frame(1, 20); tick(); tick();
    check("t3_runt",  32'(runt_cnt),  32'd1);
    check("t3_valid", 32'(frm_valid), 32'd0);
    check("t3_drop",  32'(drop_cnt),  32'd1);
    check_writes("t3_wr", 20, 0);

    // Oversize frame: 1024 writes then drop; next legal frame reuses slot 0
    wa.delete(); wd.delete();
    frame(1, 1025); tick(); tick();
    check_writes("t4_wr", 1024, 0);
    check("t4_drop",  32'(drop_cnt),  32'd2);
    check("t4_valid", 32'(frm_valid), 32'd0);
    wa.delete(); wd.delete();
    frame(7, 64); tick();
    check("t4_next_valid", 32'(frm_valid), 32'd1);
    check("t4_next_slot",  32'(frm_slot),  32'd0);
    check("t4_next_len",   32'(frm_len),   32'(LEN64));
    check_writes("t4_next_wr", 64, 0);

    // Bad first byte, then reset in the middle of a frame
    do_reset();
    wa.delete(); wd.delete();
    byte_in(8'hAA);
    for (int i = 0; i < 3; i++) byte_in(8'h55);
    byte_in(8'hD5);
    for (int i = 0; i < 5; i++) byte_in(8'(i));
    rx_dv = 1'b0;
    tick(); tick();
    check("t5_drop",  32'(drop_cnt),  32'd1);
    check("t5_wr_none", 32'(wa.size()), 32'd0);
    for (int i = 0; i < 7; i++) byte_in(8'h55);
    byte_in(8'hD5);
    for (int i = 0; i < 30; i++) byte_in(8'(i));
    reset_n = 1'b0;
    tick(); tick();
    check_all_zero("t5_rst");
    rx_dv   = 1'b0;
    reset_n = 1'b1;
    wa.delete(); wd.delete();
    tick(); tick(); tick();
    check("t5_no_commit", 32'(frm_valid), 32'd0);
    check("t5_no_wr",     32'(wa.size()), 32'd0);

    // Commit of slot 1 coincides with ack of slot 0
    frame(7, 64); tick(); tick();
    check("t6_first_valid", 32'(frm_valid), 32'd1);
    frame(7, 64);
    ack_once();
    check("t6_valid", 32'(frm_valid), 32'd1);
    check("t6_slot",  32'(frm_slot),  32'd1);
    check("t6_len",   32'(frm_len),   32'(LEN64));
    ack_once();
    check("t6_slot0_empty", 32'(frm_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
